// File: rtl/im_data_streamer.sv
// im_data_streamer: streams a CSR-described memory region into one IM port as lowdim addresses or highdim HVs
module im_data_streamer #(
  parameter int HVDimension   = 512,
  parameter int ImAddrWidth   = 32,
  parameter int MemDataWidth  = 64,
  parameter int MemAddrWidth  = 32,
  parameter int RspFifoDepth  = 4,
  parameter int NumItemsWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     start_i,
  input  logic                     mode_highdim_i,
  input  logic [MemAddrWidth-1:0]  base_addr_i,
  input  logic [MemAddrWidth-1:0]  stride_i,
  input  logic [NumItemsWidth-1:0] num_items_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [MemAddrWidth-1:0]  mem_req_addr_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  input  logic [MemDataWidth-1:0]  mem_rsp_data_i,
  input  logic                     mem_rsp_valid_i,
  output logic [ImAddrWidth-1:0]   lowdim_data_o,
  output logic [HVDimension-1:0]   highdim_data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i
);
  localparam int NumBeats = HVDimension / MemDataWidth;
  localparam int BW = NumBeats > 1 ? $clog2(NumBeats) : 1;
  localparam int CW = $clog2(RspFifoDepth + 1);
  localparam int PW = $clog2(RspFifoDepth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state, state_nxt;

  logic                     mode, zero_done;
  logic [MemAddrWidth-1:0]  stride, item_addr;
  logic [NumItemsWidth-1:0] num, req_item, out_item;
  logic [BW-1:0]            req_beat, asm_beat;
  logic [CW-1:0]            outstanding, outstanding_nxt, discard, fifo_count;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [MemDataWidth-1:0]  fifo_mem [RspFifoDepth];
  logic [MemDataWidth-1:0]  beat_data;
  logic [HVDimension-1:0]   asm_hv, out_data, item;
  logic start_ok, req_fire, req_last, req_done_last, rsp_take, beat_avail;
  logic asm_last, can_load, pop, fifo_pop, push, hs, last_hs;

  assign start_ok        = state == IDLE && start_i && outstanding == '0 && !clr_i;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;
  assign req_last        = !mode || req_beat == BW'(NumBeats - 1);
  assign req_done_last   = req_fire && req_last && req_item == num - NumItemsWidth'(1);
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_rsp_valid_i);
  assign mem_req_addr_o  = item_addr + MemAddrWidth'(req_beat);
  // Beats bypass an empty FIFO so a response can land in the output register next cycle
  assign rsp_take   = mem_rsp_valid_i && discard == '0;
  assign beat_avail = fifo_count != '0 || rsp_take;
  assign beat_data  = fifo_count != '0 ? fifo_mem[rd_ptr] : mem_rsp_data_i;
  assign asm_last   = !mode || asm_beat == BW'(NumBeats - 1);
  assign can_load   = !data_valid_o || data_ready_i;
  assign pop        = beat_avail && (!asm_last || can_load);
  assign fifo_pop   = pop && fifo_count != '0;
  assign push       = rsp_take && !(pop && fifo_count == '0);
  assign hs         = data_valid_o && data_ready_i;
  assign last_hs    = hs && out_item == num - NumItemsWidth'(1);

  assign lowdim_data_o  = mode ? '0 : out_data[ImAddrWidth-1:0];
  assign highdim_data_o = mode ? out_data : '0;

  always_comb begin
    item = asm_hv;
    item[asm_beat*MemDataWidth +: MemDataWidth] = beat_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;

  always_comb
    state_nxt = clr_i                                           ? IDLE  :
                (start_ok && num_items_i != '0)                 ? RUN   :
                (state == RUN && req_done_last)                 ? DRAIN :
                (state == DRAIN && last_hs)                     ? IDLE  : state;

  always_comb begin
    busy_o          = state != IDLE;
    done_o          = !clr_i && (zero_done || (state == DRAIN && last_hs));
    mem_req_valid_o = state == RUN &&
                      (CW+1)'(fifo_count) + (CW+1)'(outstanding) < (CW+1)'(RspFifoDepth);
  end

  always_ff @(posedge clk_i)
    if (push && !clr_i) fifo_mem[wr_ptr] <= mem_rsp_data_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mode         <= 1'b0;
      zero_done    <= 1'b0;
      stride       <= '0;
      item_addr    <= '0;
      num          <= '0;
      req_item     <= '0;
      out_item     <= '0;
      req_beat     <= '0;
      asm_beat     <= '0;
      outstanding  <= '0;
      discard      <= '0;
      fifo_count   <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      asm_hv       <= '0;
      out_data     <= '0;
      data_valid_o <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      zero_done   <= start_ok && num_items_i == '0;
      if (clr_i) begin
        // In-flight responses must still be swallowed after a clear
        discard      <= outstanding_nxt;
        fifo_count   <= '0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        asm_beat     <= '0;
        asm_hv       <= '0;
        out_data     <= '0;
        req_beat     <= '0;
        req_item     <= '0;
        out_item     <= '0;
        data_valid_o <= 1'b0;
      end else begin
        if (mem_rsp_valid_i && discard != '0) discard <= discard - CW'(1);
        if (req_fire) begin
          req_beat <= req_last ? '0 : req_beat + BW'(1);
          if (req_last) begin
            item_addr <= item_addr + stride;
            req_item  <= req_item + NumItemsWidth'(1);
          end
        end
        if (push) wr_ptr <= wr_ptr == PW'(RspFifoDepth - 1) ? '0 : wr_ptr + PW'(1);
        if (fifo_pop) rd_ptr <= rd_ptr == PW'(RspFifoDepth - 1) ? '0 : rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(fifo_pop);
        if (pop) begin
          asm_beat <= asm_last ? '0 : asm_beat + BW'(1);
          if (!asm_last) asm_hv <= item;
        end
        if (pop && asm_last) begin
          out_data     <= item;
          data_valid_o <= 1'b1;
        end else if (hs) data_valid_o <= 1'b0;
        if (hs) out_item <= out_item + NumItemsWidth'(1);
        if (start_ok) begin
          mode      <= mode_highdim_i;
          item_addr <= base_addr_i;
          stride    <= stride_i;
          num       <= num_items_i;
          req_item  <= '0;
          req_beat  <= '0;
          out_item  <= '0;
        end
      end
    end

  always_ff @(posedge clk_i)
    if (rst_ni && !clr_i && push) assert (fifo_count < CW'(RspFifoDepth));
endmodule

// File: tb/tb_im_data_streamer.sv
// tb_im_data_streamer: directed bench with a latency-programmable memory responder and handshake monitor
module tb_im_data_streamer;
  logic         clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0, start_i = 1'b0, mode_highdim_i = 1'b0;
  logic [31:0]  base_addr_i = '0, stride_i = '0;
  logic [15:0]  num_items_i = '0;
  logic         busy_o, done_o, mem_req_valid_o, data_valid_o;
  logic [31:0]  mem_req_addr_o, lowdim_data_o;
  logic         mem_req_ready_i = 1'b1, mem_rsp_valid_i = 1'b0, data_ready_i = 1'b1;
  logic [63:0]  mem_rsp_data_i = '0;
  logic [511:0] highdim_data_o;

  im_data_streamer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .start_i(start_i),
    .mode_highdim_i(mode_highdim_i), .base_addr_i(base_addr_i), .stride_i(stride_i),
    .num_items_i(num_items_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .lowdim_data_o(lowdim_data_o),
    .highdim_data_o(highdim_data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] a; int due;} req_t;
  req_t         pend[$];
  logic [31:0]  got_addr[$], got_low[$];
  logic [511:0] got_high[$];
  int           hs_cyc[$], rsp_cyc[$], done_cyc[$];
  int           total = 0, bad = 0, cyc = 0, lat = 1, max_pend = 0, stab_err = 0, start_cyc = 0;
  bit           busy_seen = 1'b0, pv = 1'b0, pr = 1'b0;
  logic [31:0]  pl = '0;
  logic [511:0] ph = '0;

  function automatic logic [63:0] mdata(input logic [31:0] a);
    return {a * 32'd3, a ^ 32'h5A5A_1234};
  endfunction

  function automatic logic [31:0] litem(input logic [31:0] a);
    logic [63:0] d;
    d = mdata(a);
    return d[31:0];
  endfunction

  function automatic logic [511:0] hv(input logic [31:0] b, input int k, input logic [31:0] s);
    logic [511:0] r;
    for (int j = 0; j < 8; j++) r[j*64 +: 64] = mdata(b + k * s + j);
    return r;
  endfunction

  // Memory responder: fixed latency, in order
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mdata(pend[0].a);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
    end
  end

  always @(negedge clk_i) begin
    if (mem_req_valid_o && mem_req_ready_i) begin
      pend.push_back('{mem_req_addr_o, cyc + lat});
      got_addr.push_back(mem_req_addr_o);
    end
    if (pend.size() > max_pend) max_pend = pend.size();
    if (mem_rsp_valid_i) rsp_cyc.push_back(cyc);
    if (data_valid_o && data_ready_i) begin
      got_low.push_back(lowdim_data_o);
      got_high.push_back(highdim_data_o);
      hs_cyc.push_back(cyc);
    end
    if (done_o) done_cyc.push_back(cyc);
    if (busy_o) busy_seen = 1'b1;
    if (pv && !pr && (!data_valid_o || lowdim_data_o !== pl || highdim_data_o !== ph)) stab_err++;
    pv = data_valid_o; pr = data_ready_i; pl = lowdim_data_o; ph = highdim_data_o;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic clear_mon();
    got_addr.delete(); got_low.delete(); got_high.delete();
    hs_cyc.delete(); rsp_cyc.delete(); done_cyc.delete();
    max_pend = 0; stab_err = 0; busy_seen = 1'b0;
  endtask

  task automatic start_job(input logic m, input logic [31:0] b, input logic [31:0] s, input logic [15:0] n);
    clear_mon();
    mode_highdim_i = m; base_addr_i = b; stride_i = s; num_items_i = n;
    start_i = 1'b1;
    start_cyc = cyc;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_cyc.size() == 0 && n < limit) begin step(1); n++; end
    step(2);
    check({tag, "_done_once"}, done_cyc.size(), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req_valid", mem_req_valid_o, 0);
    check("rst_req_addr", mem_req_addr_o, 0);
    check("rst_data_valid", data_valid_o, 0);
    check("rst_lowdim", lowdim_data_o, 0);
    check("rst_highdim", highdim_data_o, 0);
    rst_ni = 1'b1;
    step(2);

    start_job(1'b0, 32'h100, 32'd1, 16'd4);
    wait_done("low", 50);
    check("low_nreq", got_addr.size(), 4);
    check("low_nitem", got_low.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("low_addr", got_addr[i], 32'h100 + i);
      check("low_item", got_low[i], litem(32'h100 + i));
    end
    check("low_latency", hs_cyc[0], rsp_cyc[0] + 1);
    check("low_tput", hs_cyc[3] - hs_cyc[0], 3);
    check("low_done_cyc", done_cyc[0], hs_cyc[3]);

    start_job(1'b1, 32'h40, 32'd8, 16'd2);
    wait_done("high", 100);
    check("high_nreq", got_addr.size(), 16);
    for (int i = 0; i < 16; i++) check("high_addr", got_addr[i], 32'h40 + i);
    check("high_nitem", got_high.size(), 2);
    check("high_hv0", got_high[0], hv(32'h40, 0, 32'd8));
    check("high_hv1", got_high[1], hv(32'h40, 1, 32'd8));
    check("high_lowdim_zero", got_low[0], 0);
    check("high_latency", hs_cyc[0], rsp_cyc[7] + 1);
    check("high_tput", hs_cyc[1] - hs_cyc[0], 8);
    check("high_done_cyc", done_cyc[0], hs_cyc[1]);

    data_ready_i = 1'b0;
    start_job(1'b0, 32'h500, 32'd1, 16'd8);
    step(20);
    check("bp_reqs_stalled", got_addr.size(), 5);
    check("bp_valid_held", data_valid_o, 1);
    check("bp_item_held", lowdim_data_o, litem(32'h500));
    data_ready_i = 1'b1;
    wait_done("bp", 100);
    check("bp_inflight_le_depth", max_pend <= 4, 1);
    check("bp_stable", stab_err, 0);
    check("bp_nitem", got_low.size(), 8);
    for (int i = 0; i < 8; i++) check("bp_item", got_low[i], litem(32'h500 + i));

    start_job(1'b0, 32'hFFFF_FFFE, 32'd1, 16'd4);
    wait_done("wrap", 50);
    check("wrap_addr0", got_addr[0], 32'hFFFF_FFFE);
    check("wrap_addr1", got_addr[1], 32'hFFFF_FFFF);
    check("wrap_addr2", got_addr[2], 32'h0000_0000);
    check("wrap_addr3", got_addr[3], 32'h0000_0001);
    check("wrap_item2", got_low[2], litem(32'h0));

    start_job(1'b0, 32'h300, 32'd1, 16'd0);
    step(3);
    check("zero_done_n", done_cyc.size(), 1);
    check("zero_done_cyc", done_cyc[0], start_cyc + 1);
    check("zero_nreq", got_addr.size(), 0);
    check("zero_busy", busy_seen, 0);

    lat = 5;
    start_job(1'b0, 32'h600, 32'd1, 16'd8);
    step(2);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_valid", data_valid_o, 0);
    check("clr_nreq", got_addr.size(), 3);
    base_addr_i = 32'h700; num_items_i = 16'd2; start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    check("clr_start_ignored", busy_o, 0);
    step(8);
    check("clr_late_rsp", rsp_cyc.size(), 3);
    check("clr_no_new_req", got_addr.size(), 3);
    check("clr_dropped", got_low.size(), 0);
    check("clr_no_done", done_cyc.size(), 0);

    lat = 1;
    start_job(1'b0, 32'h200, 32'd2, 16'd3);
    wait_done("post", 50);
    check("post_nitem", got_low.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("post_addr", got_addr[i], 32'h200 + 2 * i);
      check("post_item", got_low[i], litem(32'h200 + 2 * i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
